// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
// State encoding, default widths and the instruction width.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;
  localparam int INSTR_W    = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts busy cycles without mem_ready and flags expiry on the
// cycle whose edge would complete the TIMEOUT-th such cycle.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic busy_i,
  input  logic ready_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = busy_i && !ready_i
                  && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!busy_i || ready_i || expired_o)
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access,
// with fetch fairness, flush draining, timeout and misalignment errors.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int TIMEOUT    = 16,
  parameter int FAIR_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  input  logic               if_flush,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_rdata,
  output logic               if_stall,
  input  logic               dm_req,
  input  logic               dm_we,
  input  logic [ADDR_W-1:0]  dm_addr,
  input  logic [DATA_W-1:0]  dm_wdata,
  output logic [DATA_W-1:0]  dm_rdata,
  output logic               dm_done,
  output logic               dm_stall,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ready,
  output logic               err
);

  localparam int FW = $clog2(FAIR_LIMIT + 1);

  logic [1:0]         state_q, state_d;
  logic [FW-1:0]      fair_q, fair_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               isel_q, isel_d;
  logic               ifv_q, ifv_d;
  logic [INSTR_W-1:0] ifr_q, ifr_d;
  logic               dmd_q, dmd_d;
  logic [DATA_W-1:0]  dmr_q, dmr_d;

  logic               busy, tmo;
  logic               fetch_ok, fair_hit;
  logic               grant_f, grant_d;
  logic               dm_mis;
  logic [INSTR_W-1:0] instr;
  logic               unused_ok;

  assign unused_ok = ^if_addr[1:0];

  assign busy     = state_q != S_IDLE;
  assign fetch_ok = if_req && !if_flush;
  assign fair_hit = fair_q == FW'(FAIR_LIMIT);
  assign grant_f  = fetch_ok && (fair_hit || !dm_req);
  assign grant_d  = dm_req && !grant_f;
  assign dm_mis   = dm_addr[2:0] != 3'b000;
  assign instr    = isel_q ? mem_rdata[2*INSTR_W-1:INSTR_W]
                           : mem_rdata[INSTR_W-1:0];

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk       (clk),
    .reset     (reset),
    .busy_i    (busy),
    .ready_i   (mem_ready),
    .expired_o (tmo)
  );

  always_comb begin
    state_d = state_q;
    fair_d  = fair_q;
    err_d   = err_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    isel_d  = isel_q;
    ifv_d   = 1'b0;
    ifr_d   = ifr_q;
    dmd_d   = 1'b0;
    dmr_d   = dmr_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_f) begin
          state_d = S_FETCH;
          addr_d  = {if_addr[ADDR_W-1:3], 3'b000};
          we_d    = 1'b0;
          wdata_d = '0;
          isel_d  = if_addr[2];
          fair_d  = '0;
        end else if (grant_d) begin
          // misaligned data access completes at once, never touches memory
          if (dm_mis) begin
            err_d = 1'b1;
            dmd_d = 1'b1;
            dmr_d = '0;
          end else begin
            state_d = S_DATA;
            addr_d  = dm_addr;
            we_d    = dm_we;
            wdata_d = dm_wdata;
            if (if_req && !fair_hit)
              fair_d = fair_q + 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_IDLE;
          ifv_d   = !if_flush;
          ifr_d   = instr;
        end else if (tmo) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          ifv_d   = !if_flush;
          ifr_d   = '0;
        end else if (if_flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DATA: begin
        if (mem_ready) begin
          state_d = S_IDLE;
          dmd_d   = 1'b1;
          dmr_d   = mem_rdata;
        end else if (tmo) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          dmd_d   = 1'b1;
          dmr_d   = '0;
        end
      end
      S_DRAIN: begin
        if (mem_ready) begin
          state_d = S_IDLE;
        end else if (tmo) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!if_req)
      fair_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      fair_q  <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      isel_q  <= 1'b0;
      ifv_q   <= 1'b0;
      ifr_q   <= '0;
      dmd_q   <= 1'b0;
      dmr_q   <= '0;
    end else begin
      state_q <= state_d;
      fair_q  <= fair_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      isel_q  <= isel_d;
      ifv_q   <= ifv_d;
      ifr_q   <= ifr_d;
      dmd_q   <= dmd_d;
      dmr_q   <= dmr_d;
    end
  end

  assign mem_req   = busy;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_valid  = ifv_q;
  assign if_rdata  = ifr_q;
  assign if_stall  = if_req && !ifv_q;
  assign dm_done   = dmd_q;
  assign dm_rdata  = dmr_q;
  assign dm_stall  = dm_req && !dmd_q;
  assign err       = err_q;

endmodule
